// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment glyph type, digit count and patterns ({g,f,e,d,c,b,a}, 1 = lit)
package seg_pkg;
  typedef logic [6:0] seg_t;
  localparam int NDIG = 6;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF = 7'h00;
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: combinational BCD to 7-segment glyph decode; codes above 9 show a dash
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);
  // decimal digits map to their glyphs, invalid BCD falls through to the dash
  always_comb
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
endmodule

// File: rtl/seg_scan.sv
// seg_scan: 6-digit multiplexed 7-segment scanner with per-frame snapshot, slot blanking and lamp test; define SEG_SCAN_BLINK_EN for digit blinking
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = 4,
  parameter int BLANK = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic       fs,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [1:0] mk,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] sel
);
  localparam logic [7:0] PMAX = 8'(DIV - 1);
  localparam logic [7:0] PBLK = 8'(BLANK);
  localparam logic POL = SEG_ACT_LOW != 0;
  logic [7:0] pcnt;
  logic [2:0] idx;
  logic [4*NDIG-1:0] snap;
  logic [1:0] mk_l;
  logic slot_end, frame_end, lit, lamp, dark, dp_n;
  logic [3:0] digit;
  logic [5:0] sel_n;
  seg_t glyph, seg_n;
  assign slot_end = pcnt == PMAX;
  assign frame_end = slot_end && idx == 3'(NDIG - 1);
  assign lit = pcnt >= PBLK;
  assign lamp = mk_l == 2'b11;
  assign digit = snap[{idx, 2'b00} +: 4];
  bcd7seg u_dec (
    .bcd(digit),
    .seg(glyph)
  );
  // scan position plus the latches that only move on slot or frame boundaries
  always_ff @(posedge fs or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      idx <= '0;
      snap <= '0;
      mk_l <= '0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + 8'd1;
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + 3'd1;
        mk_l <= mk;
      end
      if (frame_end) snap <= {f, e, d, c, b, a};
    end
`ifdef SEG_SCAN_BLINK_EN
  logic [5:0] bcnt, bmask;
  // frame counter and blink mask advance together with the snapshot
  always_ff @(posedge fs or negedge rst_n)
    if (!rst_n) begin
      bcnt <= '0;
      bmask <= '0;
    end else if (frame_end) begin
      bcnt <= bcnt + 6'd1;
      bmask <= blink_mask;
    end
  assign dark = bcnt[5] & bmask[idx];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign dark = 1'b0;
`endif
  // next pin values from the current scan position; blanking overrides lamp test and blink
  always_comb begin
    sel_n = lit ? 6'(1) << idx : '0;
    seg_n = !lit ? SEG_OFF : lamp ? SEG_8 : dark ? SEG_OFF : glyph;
    dp_n = lit && (lamp || (!dark && (idx == 3'd2 || idx == 3'd4)));
  end
  // pins are registered with polarity applied, so reset lands directly on "off"
  always_ff @(posedge fs or negedge rst_n)
    if (!rst_n) begin
      seg <= {7{POL}};
      dp <= POL;
      sel <= {6{POL}};
    end else begin
      seg <= seg_n ^ {7{POL}};
      dp <= dp_n ^ POL;
      sel <= sel_n ^ {6{POL}};
    end
endmodule
